// File: rtl/fp_pkg.sv
// Shared types and constants for the FP register file slice.
// Helper for range checking indices against a non-power-of-two depth.
package fp_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_DEPTH  = 32;
  localparam int FP_ADDR_W = $clog2(FP_DEPTH);

  typedef logic [FP_DATA_W-1:0] fp_reg_t;
  typedef logic [FP_ADDR_W-1:0] fp_addr_t;

  function automatic logic addr_ok(
    input logic [31:0] a,
    input int          depth
  );
    return a < 32'(depth);
  endfunction

endpackage

// File: rtl/fp_regfile_sb_if.sv
// Issue/read/writeback bundle of the FP register file.
// slave is the register file side, master the pipeline side.
interface fp_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ready;
  logic              wr0_valid;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_valid;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              wr_conflict;
  logic [ADDR_W:0]   pending_cnt;

  modport slave (
    input  rd_addr_a, rd_addr_b,
    input  rsv_valid, rsv_addr,
    input  wr0_valid, wr0_addr, wr0_data,
    input  wr1_valid, wr1_addr, wr1_data,
    output rd_data_a, rd_data_b,
    output rd_busy_a, rd_busy_b,
    output rsv_ready, wr_conflict, pending_cnt
  );

  modport master (
    output rd_addr_a, rd_addr_b,
    output rsv_valid, rsv_addr,
    output wr0_valid, wr0_addr, wr0_data,
    output wr1_valid, wr1_addr, wr1_data,
    input  rd_data_a, rd_data_b,
    input  rd_busy_a, rd_busy_b,
    input  rsv_ready, wr_conflict, pending_cnt
  );

endinterface

// File: rtl/fp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on reservation,
// cleared by writeback; a same-cycle reservation re-sets the bit.
module fp_scoreboard
  import fp_pkg::*;
#(
  parameter int DEPTH  = FP_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              w0_en,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic              w1_en,
  input  logic [ADDR_W-1:0] w1_addr,
  output logic              rsv_ready,
  output logic [DEPTH-1:0]  pending,
  output logic [ADDR_W:0]   pending_cnt,
  output logic              wr_conflict
);

  logic [DEPTH-1:0] clr;
  logic [DEPTH-1:0] set;
  logic [DEPTH-1:0] nxt;
  logic [ADDR_W:0]  cnt_nxt;
  logic             rsv_hit;

  always_comb begin
    clr       = '0;
    set       = '0;
    cnt_nxt   = '0;
    rsv_hit   = (w0_en && w0_addr == rsv_addr) ||
                (w1_en && w1_addr == rsv_addr);
    rsv_ready = reset && rsv_valid &&
                addr_ok(32'(rsv_addr), DEPTH) &&
                (!pending[rsv_addr] || rsv_hit);
    for (int i = 0; i < DEPTH; i++) begin
      clr[i] = (w0_en && w0_addr == ADDR_W'(i)) ||
               (w1_en && w1_addr == ADDR_W'(i));
      set[i] = rsv_ready && rsv_addr == ADDR_W'(i);
    end
    nxt = (pending & ~clr) | set;
    // count is recomputed from the next vector so it can never drift
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(nxt[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      pending_cnt <= '0;
      wr_conflict <= 1'b0;
    end else begin
      pending     <= nxt;
      pending_cnt <= cnt_nxt;
      wr_conflict <= w0_en && w1_en && w0_addr == w1_addr;
    end
  end

endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file: 2 read / 2 write ports, optional write bypass,
// pending-write scoreboard for issue-time WAW/RAW tracking.
module fp_regfile_sb
  import fp_pkg::*;
#(
  parameter int DATA_W = FP_DATA_W,
  parameter int DEPTH  = FP_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BYPASS = 1
) (
  input logic           clk,
  input logic           reset,
  fp_regfile_sb_if.slave bus
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              w0_en;
  logic              w1_en;
  logic [ADDR_W-1:0] ra    [2];
  logic [DATA_W-1:0] rdat  [2];
  logic              rbusy [2];

  assign w0_en = reset && bus.wr0_valid &&
                 addr_ok(32'(bus.wr0_addr), DEPTH);
  assign w1_en = reset && bus.wr1_valid &&
                 addr_ok(32'(bus.wr1_addr), DEPTH);

  fp_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .rsv_valid   (bus.rsv_valid),
    .rsv_addr    (bus.rsv_addr),
    .w0_en       (w0_en),
    .w0_addr     (bus.wr0_addr),
    .w1_en       (w1_en),
    .w1_addr     (bus.wr1_addr),
    .rsv_ready   (bus.rsv_ready),
    .pending     (pending),
    .pending_cnt (bus.pending_cnt),
    .wr_conflict (bus.wr_conflict)
  );

  // wr0 is written last so it wins a same-index double write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (w1_en) regs[bus.wr1_addr] <= bus.wr1_data;
      if (w0_en) regs[bus.wr0_addr] <= bus.wr0_data;
    end
  end

  assign ra[0] = bus.rd_addr_a;
  assign ra[1] = bus.rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p]  = '0;
      rbusy[p] = 1'b0;
      if (addr_ok(32'(ra[p]), DEPTH)) begin
        rdat[p]  = regs[ra[p]];
        rbusy[p] = pending[ra[p]];
        if (BYPASS != 0 && w0_en && bus.wr0_addr == ra[p]) begin
          rdat[p]  = bus.wr0_data;
          rbusy[p] = 1'b0;
        end else if (BYPASS != 0 && w1_en && bus.wr1_addr == ra[p]) begin
          rdat[p]  = bus.wr1_data;
          rbusy[p] = 1'b0;
        end
      end
    end
  end

  assign bus.rd_data_a = rdat[0];
  assign bus.rd_data_b = rdat[1];
  assign bus.rd_busy_a = rbusy[0];
  assign bus.rd_busy_b = rbusy[1];

endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
- Parametrised floating-point register file with 2 read ports, 2 write ports and a per-register pending-write scoreboard.
- Write port 0 is the FPU writeback; write port 1 is the FP load return.
- Issue logic reserves a destination register, then reads operands with busy flags. Writes clear the reservation.
- Same-cycle write-to-read bypass is optional.

Parameters:
- DATA_W, 32, register width in bits (32 single, 64 double)
- DEPTH, 32, number of registers
- ADDR_W, $clog2(DEPTH), register index width
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-low
- rd_addr_a  in  ADDR_W  read port A index
- rd_addr_b  in  ADDR_W  read port B index
- rd_data_a  out  DATA_W  port A data (combinational)
- rd_data_b  out  DATA_W  port B data (combinational)
- rd_busy_a  out  1  port A register has a pending write (combinational)
- rd_busy_b  out  1  port B register has a pending write (combinational)
- rsv_valid  in  1  issue requests reservation of rsv_addr
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ready  out  1  reservation accepted this cycle (combinational)
- wr0_valid  in  1  FPU writeback valid
- wr0_addr  in  ADDR_W  FPU writeback index
- wr0_data  in  DATA_W  FPU writeback data
- wr1_valid  in  1  load writeback valid
- wr1_addr  in  ADDR_W  load writeback index
- wr1_data  in  DATA_W  load writeback data
- wr_conflict  out  1  registered one-cycle pulse: both write ports targeted the same index last cycle
- pending_cnt  out  ADDR_W+1  registered count of set pending bits

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0, all pending bits = 0
  - wr_conflict = 0, pending_cnt = 0
  - held while reset low; no writes or reservations accepted
- Write:
  - wrN_valid at an edge stores wrN_data into registers[wrN_addr] and clears pending[wrN_addr].
  - Latency 1: value is visible on read ports the cycle after the edge (or the same cycle with BYPASS=1).
- Dual write to the same index:
  - wr0 wins the data; pending is cleared.
  - wr_conflict = 1 for exactly the following cycle, then 0.
  - Different indices: both writes commit.
- Reservation:
  - rsv_ready = rsv_valid && (!pending[rsv_addr] || write to rsv_addr this cycle).
  - On an edge with rsv_ready=1, pending[rsv_addr] is set.
  - A reservation with a same-cycle write to the same index: the write data commits and pending ends at 1 (the new owner wins).
  - rsv_ready=0 means a WAW hazard; the issuer holds rsv_valid/rsv_addr until it is accepted. No internal queueing.
- Read:
  - rd_data_x = registers[rd_addr_x].
  - With BYPASS=1, if a write to rd_addr_x is valid this cycle, rd_data_x returns that write's data (wr0 over wr1) and rd_busy_x = 0.
  - Otherwise rd_busy_x = pending[rd_addr_x].
  - Reservation does not affect read values in the same cycle.
- pending_cnt:
  - Next value = current + (accepted reservation that sets a clear bit) - (bits cleared by writes, counting a double write to one index once).
  - Must always equal popcount(pending).
  - Range 0..DEPTH; cannot wrap, since a bit can only be set once.
- Addresses >= DEPTH (non-power-of-two DEPTH):
  - writes ignored, reservations rejected (rsv_ready=0), reads return 0 with busy 0.
- Write to a non-pending register: legal, data commits, pending stays 0.
- Reset asserted mid-operation: all pending reservations are discarded; the issuer must not assume prior reservations survive.

Decomposition:
- Shared package fp_pkg:
  - FP_DATA_W, FP_DEPTH, FP_ADDR_W constants
  - fp_reg_t typedef (logic [FP_DATA_W-1:0])
  - fp_addr_t typedef
- Sub-module fp_scoreboard:
  - pending bit vector, rsv_ready logic, write-clear logic, pending_cnt
  - instantiated once; the data array and bypass muxes stay in the top

Test Plan:
- Reset release -> all 32 reads return 0x00000000 with busy 0; pending_cnt=0; wr_conflict=0.
- rsv_valid addr 5 (accepted) -> rd_busy_a=1 on addr 5, pending_cnt=1; wr0 addr 5 data 0x3F800000 -> same-cycle rd_data_a=0x3F800000 busy 0 (BYPASS=1); next cycle stored, pending_cnt=0.
- Addr 7 pending, second rsv_valid addr 7 -> rsv_ready=0 and pending_cnt unchanged; same rsv_valid in the cycle wr1 writes addr 7 with 0x40490FDB -> rsv_ready=1, register = 0x40490FDB, pending stays 1.
- wr0 addr 3 data 0x11111111 and wr1 addr 3 data 0x22222222 in the same cycle -> register 3 = 0x11111111, wr_conflict=1 for one cycle only.
- Reserve 31 registers over consecutive cycles, then drop reset low mid-sequence -> immediately all busy 0, pending_cnt 0, register 2 = 0; accepted reservations after release behave normally.
- BYPASS=0 build: wr0 addr 9 with rd_addr_b=9 in the same cycle -> rd_data_b shows the old value and busy 1 in that cycle, then the new value and busy 0 the next cycle.
